uart_rx_ctrl: RTL and testbench

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

---
 rtl/uart_pkg.sv | 17 +
 rtl/sync_2ff.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 141 ++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state encoding
package uart_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int SYS_RATE      = 100_000_000;
  localparam int BAND_RATE     = 9600;
  localparam int BIT_CLKS      = SYS_RATE / BAND_RATE;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_IDLE = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - multi-stage synchronizer, all stages preset to RESET_VAL
module sync_2ff #(
  parameter int   DEPTH     = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [DEPTH-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {DEPTH{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[DEPTH-2:0], i_d};
    end
  end

  assign o_q = r_sync[DEPTH-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART receive controller, samples rx on clk_bps from an external baud generator
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx,
  input  logic                 clk_bps,
  output logic                 band_sig,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 rx_busy
);

  localparam int CNT_W = $clog2(DATA_BITS + 1);

  uart_rx_state_e       r_state, w_state_nxt;
  logic [CNT_W-1:0]     r_bit_cnt, w_bit_cnt_nxt;
  logic [DATA_BITS-1:0] r_shift, w_shift_nxt;
  logic [DATA_BITS-1:0] r_rx_data, w_rx_data_nxt;
  logic                 r_rx_valid, w_rx_valid_nxt;
  logic                 r_frame_err, w_frame_err_nxt;
  logic                 r_band_sig, w_band_sig_nxt;
  logic                 r_rx_hist;
  logic                 w_rx_sync;
  logic                 w_fall;

  sync_2ff #(
    .DEPTH     (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx),
    .o_q   (w_rx_sync)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_hist <= 1'b1;
    end else begin
      r_rx_hist <= w_rx_sync;
    end
  end

  assign w_fall = r_rx_hist & ~w_rx_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
      r_band_sig  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_bit_cnt   <= w_bit_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_rx_data   <= w_rx_data_nxt;
      r_rx_valid  <= w_rx_valid_nxt;
      r_frame_err <= w_frame_err_nxt;
      r_band_sig  <= w_band_sig_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_bit_cnt_nxt   = r_bit_cnt;
    w_shift_nxt     = r_shift;
    w_rx_data_nxt   = r_rx_data;
    w_rx_valid_nxt  = 1'b0;
    w_frame_err_nxt = 1'b0;
    w_band_sig_nxt  = r_band_sig;

    case (r_state)
      ST_IDLE: begin
        if (w_fall) begin
          w_state_nxt    = ST_START;
          w_band_sig_nxt = 1'b1;
        end
      end
      ST_START: begin
        if (clk_bps) begin
          if (!w_rx_sync) begin
            w_state_nxt   = ST_DATA;
            w_bit_cnt_nxt = '0;
          end else begin
            w_state_nxt    = ST_IDLE;
            w_band_sig_nxt = 1'b0;
          end
        end
      end
      ST_DATA: begin
        // Right shift lands the first (LSB) sample in bit 0 after DATA_BITS samples.
        if (clk_bps) begin
          w_shift_nxt   = {w_rx_sync, r_shift[DATA_BITS-1:1]};
          w_bit_cnt_nxt = r_bit_cnt + CNT_W'(1);
          if (r_bit_cnt == CNT_W'(DATA_BITS - 1)) begin
            w_state_nxt = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (clk_bps) begin
          w_band_sig_nxt = 1'b0;
          if (w_rx_sync) begin
            w_rx_data_nxt  = r_shift;
            w_rx_valid_nxt = 1'b1;
            w_state_nxt    = ST_IDLE;
          end else begin
            w_frame_err_nxt = 1'b1;
            w_state_nxt     = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        // Line held low (break): wait for it to go high before re-arming edge detection.
        if (w_rx_sync) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt    = ST_IDLE;
        w_band_sig_nxt = 1'b0;
      end
    endcase
  end

  assign band_sig  = r_band_sig;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign rx_busy   = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed bench for uart_rx_ctrl with a scaled-down rx baud generator
module tb_uart_rx_ctrl;

  localparam int BIT  = 16;
  localparam int HALF = 5;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       clk_bps;
  logic       band_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       rx_busy;

  logic       r_force_bps;
  int         r_bps_cnt;

  int         n_checks;
  int         n_errors;
  int         n_valid;
  int         n_ferr;
  int         n_both;
  int         n_band_rise;
  logic       r_band_d;
  logic [7:0] q_data[$];

  uart_rx_ctrl #(
    .DATA_BITS   (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx        (rx),
    .clk_bps   (clk_bps),
    .band_sig  (band_sig),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Baud generator model: free-runs while band_sig is high, pulse near mid-bit.
  always @(posedge clk) begin
    if (!band_sig) r_bps_cnt <= 0;
    else r_bps_cnt <= (r_bps_cnt == BIT - 1) ? 0 : r_bps_cnt + 1;
  end

  assign clk_bps = (band_sig && (r_bps_cnt == HALF)) || r_force_bps;

  always @(negedge clk) begin
    if (rx_valid) begin
      n_valid = n_valid + 1;
      q_data.push_back(rx_data);
    end
    if (frame_err) n_ferr = n_ferr + 1;
    if (rx_valid && frame_err) n_both = n_both + 1;
    if (band_sig && !r_band_d) n_band_rise = n_band_rise + 1;
    r_band_d = band_sig;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop, input int stop_clks, input bit chk_rise);
    rx = 1'b0;
    if (chk_rise) begin
      wait_clks(2);
      check_eq("band_pre_rise", 32'(band_sig), 32'd0);
      wait_clks(1);
      check_eq("band_rise_3clk", 32'(band_sig), 32'd1);
      wait_clks(BIT - 3);
    end else begin
      wait_clks(BIT);
    end
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clks(BIT);
    end
    rx = stop;
    wait_clks(stop_clks);
  endtask

  int v0, f0, b0;

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    n_valid     = 0;
    n_ferr      = 0;
    n_both      = 0;
    n_band_rise = 0;
    r_band_d    = 1'b0;
    r_force_bps = 1'b0;
    rx          = 1'b1;
    rst_n       = 1'b0;
    wait_clks(3);
    check_eq("rst_band", 32'(band_sig), 32'd0);
    check_eq("rst_data", 32'(rx_data), 32'h00);
    check_eq("rst_valid", 32'(rx_valid), 32'd0);
    check_eq("rst_ferr", 32'(frame_err), 32'd0);
    check_eq("rst_busy", 32'(rx_busy), 32'd0);
    rst_n = 1'b1;
    wait_clks(4);

    // Clean 0xA5 frame
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'hA5, 1'b1, BIT, 1'b1);
    wait_clks(4);
    check_eq("a5_valid_cnt", 32'(n_valid - v0), 32'd1);
    check_eq("a5_ferr_cnt", 32'(n_ferr - f0), 32'd0);
    check_eq("a5_data", 32'(rx_data), 32'hA5);
    check_eq("a5_band_low", 32'(band_sig), 32'd0);

    // Short glitch: false start
    v0 = n_valid; f0 = n_ferr; b0 = n_band_rise;
    rx = 1'b0;
    wait_clks(BIT / 4);
    rx = 1'b1;
    wait_clks(2 * BIT);
    check_eq("glitch_band_rise", 32'(n_band_rise - b0), 32'd1);
    check_eq("glitch_band_low", 32'(band_sig), 32'd0);
    check_eq("glitch_valid", 32'(n_valid - v0), 32'd0);
    check_eq("glitch_ferr", 32'(n_ferr - f0), 32'd0);

    // 0x3C with stop bit low held for three bit times
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0, 2 * BIT, 1'b0);
    check_eq("break_busy", 32'(rx_busy), 32'd1);
    check_eq("break_band", 32'(band_sig), 32'd0);
    wait_clks(BIT);
    rx = 1'b1;
    wait_clks(2 * BIT);
    check_eq("break_ferr_cnt", 32'(n_ferr - f0), 32'd1);
    check_eq("break_valid_cnt", 32'(n_valid - v0), 32'd0);
    check_eq("break_data_kept", 32'(rx_data), 32'hA5);
    check_eq("break_idle", 32'(rx_busy), 32'd0);
    send_frame(8'h12, 1'b1, BIT, 1'b0);
    wait_clks(4);
    check_eq("after_break_valid", 32'(n_valid - v0), 32'd1);
    check_eq("after_break_data", 32'(rx_data), 32'h12);

    // Back-to-back frames, single stop bit, no gap
    v0 = n_valid;
    q_data.delete();
    send_frame(8'h00, 1'b1, BIT, 1'b0);
    send_frame(8'hFF, 1'b1, BIT, 1'b0);
    wait_clks(4);
    check_eq("b2b_valid_cnt", 32'(n_valid - v0), 32'd2);
    check_eq("b2b_first", (q_data.size() > 0) ? 32'(q_data[0]) : 32'hDEAD, 32'h00);
    check_eq("b2b_second", (q_data.size() > 1) ? 32'(q_data[1]) : 32'hDEAD, 32'hFF);

    // Reset during data bit 4 of 0x55
    rx = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx = 8'h55 >> i;
      wait_clks(BIT);
    end
    rx = 1'b0;
    wait_clks(BIT / 2);
    check_eq("pre_rst_busy", 32'(rx_busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_band", 32'(band_sig), 32'd0);
    check_eq("mid_rst_busy", 32'(rx_busy), 32'd0);
    check_eq("mid_rst_data", 32'(rx_data), 32'h00);
    rx = 1'b1;
    wait_clks(3);
    rst_n = 1'b1;
    wait_clks(4);
    v0 = n_valid;
    send_frame(8'h55, 1'b1, BIT, 1'b0);
    wait_clks(4);
    check_eq("post_rst_valid", 32'(n_valid - v0), 32'd1);
    check_eq("post_rst_data", 32'(rx_data), 32'h55);

    // clk_bps pulses while idle must be ignored
    v0 = n_valid; f0 = n_ferr; b0 = n_band_rise;
    for (int i = 0; i < 50; i++) begin
      r_force_bps = 1'b1;
      wait_clks(1);
      r_force_bps = 1'b0;
      wait_clks(1);
    end
    wait_clks(2);
    check_eq("idle_bps_busy", 32'(rx_busy), 32'd0);
    check_eq("idle_bps_band", 32'(n_band_rise - b0), 32'd0);
    check_eq("idle_bps_valid", 32'(n_valid - v0), 32'd0);
    check_eq("idle_bps_ferr", 32'(n_ferr - f0), 32'd0);
    check_eq("idle_bps_data", 32'(rx_data), 32'h55);

    check_eq("valid_ferr_overlap", 32'(n_both), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
